// File: rtl/pattern_sequencer.sv
// pattern_sequencer: steps through a small programmable pattern memory on counter-bit rising edges.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   currentCount, mask  free-running count and tick-bit select; level = |(currentCount & mask)
//   run, mode           1 = sequence / 0 = idle; 0 = forward-wrap / 1 = ping-pong
//   last_step           highest step index used
//   wr_en, wr_addr,     pattern memory write port, accepted in every state
//   wr_data
//   pattern_out         registered current pattern word
//   step_idx            registered current step index
//   step_tick, wrap     one-cycle pulses on each advance / on sequencing back to index 0
module pattern_sequencer #(
    parameter int STEPS = 8,
    parameter int DW = 8,
    localparam int SW = $clog2(STEPS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [15:0]   currentCount,
    input  logic [15:0]   mask,
    input  logic          run,
    input  logic          mode,
    input  logic [SW-1:0] last_step,
    input  logic          wr_en,
    input  logic [SW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] pattern_out,
    output logic [SW-1:0] step_idx,
    output logic          step_tick,
    output logic          wrap
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nxt;
    logic [DW-1:0] mem [STEPS];
    logic prev_l, lvl, tick;
    logic dir, dir_nxt, adv_dir;
    logic [SW-1:0] adv, ld_addr, idx_nxt;
    logic [DW-1:0] ld_word, pat_nxt;
    logic tick_nxt, wrap_nxt;

    assign lvl = |(currentCount & mask);
    assign tick = lvl & ~prev_l;

    // dir: 0 = up, 1 = down; only consulted in ping-pong mode, kept untouched in forward mode
    always_comb begin
        adv_dir = dir;
        adv = '0;
        if (!mode)
            adv = (step_idx >= last_step) ? '0 : step_idx + SW'(1);
        else if (!dir) begin
            adv_dir = step_idx >= last_step;
            adv = (step_idx < last_step) ? step_idx + SW'(1) : (step_idx == '0) ? '0 : step_idx - SW'(1);
        end else begin
            adv_dir = step_idx != '0;
            adv = (step_idx != '0) ? step_idx - SW'(1) : (last_step == '0) ? '0 : SW'(1);
        end
    end

    // write-first: a word loaded on the same edge as a write to its address takes the new data
    assign ld_addr = (state == IDLE) ? '0 : adv;
    assign ld_word = (wr_en && wr_addr == ld_addr) ? wr_data : mem[ld_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            prev_l      <= 1'b1;
            dir         <= 1'b0;
            pattern_out <= '0;
            step_idx    <= '0;
            step_tick   <= 1'b0;
            wrap        <= 1'b0;
        end else begin
            state       <= state_nxt;
            prev_l      <= lvl;
            dir         <= dir_nxt;
            pattern_out <= pat_nxt;
            step_idx    <= idx_nxt;
            step_tick   <= tick_nxt;
            wrap        <= wrap_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STEPS; i++)
                mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign state_nxt = run ? RUN : IDLE;

    // dropping run outranks a simultaneous tick; entering RUN never produces a step_tick
    always_comb begin
        idx_nxt  = step_idx;
        pat_nxt  = pattern_out;
        dir_nxt  = dir;
        tick_nxt = 1'b0;
        wrap_nxt = 1'b0;
        if (!run) begin
            idx_nxt = '0;
            pat_nxt = '0;
            dir_nxt = 1'b0;
        end else if (state == IDLE) begin
            idx_nxt = '0;
            pat_nxt = ld_word;
            dir_nxt = 1'b0;
        end else if (tick) begin
            idx_nxt  = adv;
            pat_nxt  = ld_word;
            dir_nxt  = adv_dir;
            tick_nxt = 1'b1;
            wrap_nxt = (adv == '0) && (step_idx != '0);
        end
    end
endmodule

// File: tb/tb_pattern_sequencer.sv
// tb_pattern_sequencer: directed and randomized checks of pattern_sequencer against a behavioural model.
module tb_pattern_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    logic [15:0] cnt, mask;
    logic run, mode, wr_en;
    logic [2:0] last, wr_addr;
    logic [7:0] wr_data;
    logic [7:0] pattern_out;
    logic [2:0] step_idx;
    logic step_tick, wrap;

    int checks = 0;
    int errors = 0;

    bit m_run, m_down, m_prev, m_tick, m_wrap;
    int m_idx, m_pat;
    int m_mem [8];

    pattern_sequencer dut (
        .clk(clk), .rst_n(rst_n), .currentCount(cnt), .mask(mask), .run(run), .mode(mode),
        .last_step(last), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pattern_out(pattern_out), .step_idx(step_idx), .step_tick(step_tick), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_run = 0; m_down = 0; m_prev = 1; m_tick = 0; m_wrap = 0; m_idx = 0; m_pat = 0;
        for (int i = 0; i < 8; i++) m_mem[i] = 0;
    endtask

    function automatic int load(int a);
        return (wr_en && int'(wr_addr) == a) ? int'(wr_data) : m_mem[a];
    endfunction

    // advances the model by one clock edge using the inputs as they stand, then clocks the DUT
    task automatic cycle();
        bit l, t;
        int n, lst;
        l = (cnt & mask) != 0;
        t = l && !m_prev;
        lst = int'(last);
        m_tick = 0; m_wrap = 0;
        if (!run) begin
            m_run = 0; m_idx = 0; m_down = 0; m_pat = 0;
        end else if (!m_run) begin
            m_run = 1; m_idx = 0; m_down = 0; m_pat = load(0);
        end else if (t) begin
            if (!mode) n = (m_idx >= lst) ? 0 : m_idx + 1;
            else if (!m_down) begin
                if (m_idx >= lst) begin m_down = 1; n = (m_idx == 0) ? 0 : m_idx - 1; end
                else n = m_idx + 1;
            end else begin
                if (m_idx == 0) begin m_down = 0; n = (lst == 0) ? 0 : 1; end
                else n = m_idx - 1;
            end
            m_tick = 1;
            m_wrap = (n == 0) && (m_idx != 0);
            m_idx = n;
            m_pat = load(n);
        end
        m_prev = l;
        if (wr_en) m_mem[wr_addr] = int'(wr_data);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; cnt = 16'hFFFF; mask = 16'h0080; run = 0; mode = 0; last = 3;
        wr_en = 0; wr_addr = 0; wr_data = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst_n = 1;
        run = 1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if (step_tick !== 1'b0 || pattern_out !== 8'h00 || step_idx !== 3'd0) begin
                errors++;
                $display("FAIL reset_release cyc %0d: tick=%b pat=%h idx=%0d, want 0/00/0", i, step_tick, pattern_out, step_idx);
            end
        end
    endtask

    task automatic test_forward();
        logic [7:0] exp_pat [4] = '{8'h02, 8'h04, 8'h08, 8'h01};
        run = 0; cnt = 0;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1; wr_addr = 3'(i); wr_data = 8'(1 << i);
            cycle();
        end
        wr_en = 0; last = 3; mode = 0; run = 1;
        cycle();
        checks++;
        if (pattern_out !== 8'h01 || step_idx !== 3'd0 || step_tick !== 1'b0) begin
            errors++;
            $display("FAIL fwd_entry: pat=%h idx=%0d tick=%b, want 01/0/0", pattern_out, step_idx, step_tick);
        end
        for (int k = 0; k < 4; k++) begin
            cnt = 16'h0080;
            cycle();
            checks++;
            if (pattern_out !== exp_pat[k] || step_tick !== 1'b1 || wrap !== (k == 3)) begin
                errors++;
                $display("FAIL fwd_tick %0d: pat=%h tick=%b wrap=%b, want %h/1/%b", k, pattern_out, step_tick, wrap, exp_pat[k], k == 3);
            end
            cnt = 16'h0000;
            cycle();
            checks++;
            if (step_tick !== 1'b0 || wrap !== 1'b0 || pattern_out !== exp_pat[k]) begin
                errors++;
                $display("FAIL fwd_hold %0d: tick=%b wrap=%b pat=%h, want 0/0/%h", k, step_tick, wrap, pattern_out, exp_pat[k]);
            end
        end
    endtask

    task automatic test_pingpong();
        int exp_idx [7] = '{1, 2, 3, 2, 1, 0, 1};
        int wraps = 0;
        run = 0; cycle();
        mode = 1; run = 1; cycle();
        for (int k = 0; k < 7; k++) begin
            cnt = 16'h0080; cycle();
            if (wrap) wraps++;
            checks++;
            if (int'(step_idx) != exp_idx[k] || wrap !== (k == 5) || pattern_out !== 8'(1 << exp_idx[k])) begin
                errors++;
                $display("FAIL pp_tick %0d: idx=%0d wrap=%b pat=%h, want %0d/%b/%h", k, step_idx, wrap, pattern_out, exp_idx[k], k == 5, 8'(1 << exp_idx[k]));
            end
            cnt = 16'h0000; cycle();
        end
        checks++;
        if (wraps != 1) begin
            errors++;
            $display("FAIL pp_wrap_count: got %0d, want 1", wraps);
        end
    endtask

    task automatic test_write_forward();
        mode = 0; run = 0; cycle();
        run = 1; cycle();
        cnt = 16'h0080; cycle();
        cnt = 16'h0000; cycle();
        cnt = 16'h0080; wr_en = 1; wr_addr = 2; wr_data = 8'hAA; cycle();
        wr_en = 0;
        checks++;
        if (pattern_out !== 8'hAA || step_idx !== 3'd2) begin
            errors++;
            $display("FAIL write_forward: pat=%h idx=%0d, want AA/2", pattern_out, step_idx);
        end
        cnt = 16'h0000; cycle();
    endtask

    task automatic test_run_drop();
        cnt = 16'h0080; run = 0; cycle();
        checks++;
        if (pattern_out !== 8'h00 || step_idx !== 3'd0 || step_tick !== 1'b0) begin
            errors++;
            $display("FAIL run_drop: pat=%h idx=%0d tick=%b, want 00/0/0", pattern_out, step_idx, step_tick);
        end
        cnt = 16'h0000; cycle();
    endtask

    task automatic test_last_zero();
        last = 0; run = 1; cycle();
        for (int m = 0; m < 2; m++) begin
            mode = m[0];
            for (int k = 0; k < 3; k++) begin
                cnt = 16'h0080; cycle();
                checks++;
                if (step_idx !== 3'd0 || step_tick !== 1'b1 || wrap !== 1'b0 || pattern_out !== 8'h01) begin
                    errors++;
                    $display("FAIL last_zero m%0d k%0d: idx=%0d tick=%b wrap=%b pat=%h, want 0/1/0/01", m, k, step_idx, step_tick, wrap, pattern_out);
                end
                cnt = 16'h0000; cycle();
            end
        end
    endtask

    task automatic test_mask_zero();
        int ticks = 0;
        mask = 0; last = 3; mode = 0;
        for (int k = 0; k < 20; k++) begin
            cnt = 16'($urandom);
            cycle();
            if (step_tick) ticks++;
        end
        checks++;
        if (ticks != 0 || step_idx !== 3'd0) begin
            errors++;
            $display("FAIL mask_zero: ticks=%0d idx=%0d, want 0/0", ticks, step_idx);
        end
        mask = 16'h0080; cnt = 0; cycle();
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 2; k++) begin
            cnt = 16'h0000; cycle();
            cnt = 16'h0080; cycle();
        end
        checks++;
        if (step_idx !== 3'd2 || step_tick !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: idx=%0d tick=%b, want 2/1", step_idx, step_tick);
        end
        #1 rst_n = 0;
        model_reset();
        #1;
        checks++;
        if (pattern_out !== 8'h00 || step_idx !== 3'd0 || step_tick !== 1'b0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_async: pat=%h idx=%0d tick=%b wrap=%b, want all 0", pattern_out, step_idx, step_tick, wrap);
        end
        #1 rst_n = 1;
        cycle();
        checks++;
        if (pattern_out !== 8'h00 || step_tick !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_entry: pat=%h tick=%b, want 00/0", pattern_out, step_tick);
        end
        cnt = 16'h0000; cycle();
        cnt = 16'h0080; cycle();
        checks++;
        if (pattern_out !== 8'h00 || step_idx !== 3'd1) begin
            errors++;
            $display("FAIL rst_mid_memclr: pat=%h idx=%0d, want 00/1", pattern_out, step_idx);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            run = $urandom_range(0, 31) != 0;
            if ($urandom_range(0, 15) == 0) mode = 1'($urandom);
            if ($urandom_range(0, 15) == 0) last = 3'($urandom);
            if ($urandom_range(0, 63) == 0) mask = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'(1 << $urandom_range(0, 3));
            cnt = 16'($urandom);
            wr_en = $urandom_range(0, 3) == 0;
            wr_addr = 3'($urandom);
            wr_data = 8'($urandom);
            cycle();
            checks++;
            if (pattern_out !== 8'(m_pat) || step_idx !== 3'(m_idx) || step_tick !== m_tick || wrap !== m_wrap) begin
                errors++;
                $display("FAIL random %0d: pat=%h idx=%0d tick=%b wrap=%b, want %h/%0d/%b/%b", k, pattern_out, step_idx, step_tick, wrap, 8'(m_pat), m_idx, m_tick, m_wrap);
            end
        end
        wr_en = 0;
    endtask

    initial begin
        test_reset();
        test_forward();
        test_pingpong();
        test_write_forward();
        test_run_drop();
        test_last_zero();
        test_mask_zero();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pattern_sequencer.md
# pattern_sequencer

Downstream consumer of the free-running 16-bit `counter`. Edge-detects the counter bit(s) selected by a mask (the same mask convention `blinker` uses) to form a step tick, and on each tick advances through a small register-file pattern memory written from the top-level inputs. Drives an 8-bit LED pattern toward `uo_out`, so the top level can display programmable sequences instead of a single blink.

## Interface
Parameters:
- `STEPS`, 8, pattern memory depth; power of two, index width `SW = log2(STEPS)`.
- `DW`, 8, pattern word width.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `currentCount` input 16: count from `counter`.
- `mask` input 16: selects tick bit(s); level `L = |(currentCount & mask)`.
- `run` input 1: 1 = sequence, 0 = idle.
- `mode` input 1: 0 = forward-wrap, 1 = ping-pong.
- `last_step` input SW: highest step index used.
- `wr_en` input 1: pattern memory write strobe.
- `wr_addr` input SW: write address.
- `wr_data` input DW: write data.
- `pattern_out` output DW: registered current pattern word.
- `step_idx` output SW: registered current step index.
- `step_tick` output 1: one-cycle pulse on each step advance.
- `wrap` output 1: one-cycle pulse when the index returns to 0 by sequencing.

## Operation
- Reset (asynchronous): memory words = 0, `prev_L` = 1, state = IDLE, direction = up, `pattern_out` = 0, `step_idx` = 0, `step_tick` = 0, `wrap` = 0.
- `tick = L & ~prev_L`; `prev_L <= L` every cycle in every state. `mask` = 0 produces no ticks. Multiple mask bits are ORed.
- Memory write: when `wr_en` = 1, `mem[wr_addr] <= wr_data`. Writes are accepted in every state. Write-first forwarding: if a word is loaded into `pattern_out` on the same edge as a write to that address, `pattern_out` takes `wr_data`.
- States:
  - IDLE: outputs held at 0. `run` = 1 moves to RUN, loads `step_idx` = 0, loads `pattern_out` = mem[0] (forwarded), and sets direction = up. No `step_tick` is generated on entry.
  - RUN, `run` = 0: moves to IDLE and clears `pattern_out`, `step_idx`, and direction on the same edge. This has priority over a simultaneous tick.
  - RUN, tick: computes `next`, loads `step_idx` = `next` and `pattern_out` = mem[`next`], and sets `step_tick` = 1.
- Next-index rules:
  - Forward mode (`mode` = 0): `next = (idx >= last_step) ? 0 : idx + 1`. `wrap` = 1 when `next` = 0.
  - Ping-pong, direction up: at `idx >= last_step`, direction becomes down and `next = idx - 1`. If `idx` = 0, `next` = 0 instead.
  - Ping-pong, direction down: at `idx` = 0, direction becomes up and `next = 1`. If `last_step` = 0, `next` = 0 instead.
  - Ping-pong, `wrap` = 1 when `next` = 0 and `idx` ≠ 0.
  - `last_step` = 0: the index stays at 0, `step_tick` still pulses on every tick, and `wrap` stays 0.
  - `last_step` lowered below the current `idx`: the next tick yields 0 in forward mode, and down then toward 0 in ping-pong mode.
  - `mode` changed while running: takes effect at the next tick. Direction is kept; a down direction in forward mode is ignored.
- All index arithmetic is SW bits wide; no overflow is possible because of the `>=` compare.

## Timing
- A tick is seen combinationally in the cycle where sampled `L` is 1 and `prev_L` is 0. `step_idx`, `pattern_out`, and `step_tick` update on that same clock edge, which gives 1-cycle latency from the `L` rising sample.
- `step_tick` and `wrap` are high for exactly one cycle per advance.
- `run` rising: `pattern_out` = mem[0] is valid the cycle after the edge that samples `run` = 1.
- A write becomes visible on `pattern_out` only at the next load (tick or run entry), except for same-edge forwarding.
- Reset asserted mid-sequence clears all outputs immediately. After release with `L` = 1, no spurious tick occurs because `prev_L` resets to 1.

## Test plan
- Reset with `L` = 1, then release: `step_tick` stays 0, and `pattern_out` = 0, `step_idx` = 0.
- Write mem[0..3] = 0x01, 0x02, 0x04, 0x08; set `last_step` = 3, `mask` = 0x0080, `mode` = 0, `run` = 1 → `pattern_out` sequence 01, 02, 04, 08, 01, with `wrap` pulsing at the 4th tick. Each step changes one cycle after a `counter` bit-7 rise.
- Ping-pong with `last_step` = 3 → `step_idx` sequence 0, 1, 2, 3, 2, 1, 0, 1. `wrap` pulses once, on entering 0.
- Write mem[2] = 0xAA on the same cycle the tick advances to step 2 → `pattern_out` = 0xAA, not the old value.
- `run` dropped on a tick cycle → state IDLE, `pattern_out` = 0, `step_tick` = 0. With `last_step` = 0 or `mask` = 0 → the index stays at 0. `mask` = 0 gives no `step_tick`.
- Assert `rst_n` low at step 2 while running → outputs are 0 immediately and memory is cleared. After release with `run` = 1, `pattern_out` = 0x00.
